// File: rtl/mcu_pkg.sv
// Shared encodings for the RAT MCU control unit: states, opcodes,
// ALU function codes and datapath mux selects.
package mcu_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    // Full 7-bit opcodes {IR_FIVE, IR_TWO}
    localparam logic [6:0] OP_AND   = 7'd0;
    localparam logic [6:0] OP_OR    = 7'd1;
    localparam logic [6:0] OP_EXOR  = 7'd2;
    localparam logic [6:0] OP_TEST  = 7'd3;
    localparam logic [6:0] OP_ADD   = 7'd4;
    localparam logic [6:0] OP_ADDC  = 7'd5;
    localparam logic [6:0] OP_SUB   = 7'd6;
    localparam logic [6:0] OP_SUBC  = 7'd7;
    localparam logic [6:0] OP_CMP   = 7'd8;
    localparam logic [6:0] OP_MOV   = 7'd9;
    localparam logic [6:0] OP_LD    = 7'd10;
    localparam logic [6:0] OP_ST    = 7'd11;
    localparam logic [6:0] OP_BRN   = 7'd16;
    localparam logic [6:0] OP_CALL  = 7'd17;
    localparam logic [6:0] OP_BREQ  = 7'd18;
    localparam logic [6:0] OP_BRNE  = 7'd19;
    localparam logic [6:0] OP_BRCS  = 7'd20;
    localparam logic [6:0] OP_BRCC  = 7'd21;
    localparam logic [6:0] OP_LSL   = 7'd32;
    localparam logic [6:0] OP_LSR   = 7'd33;
    localparam logic [6:0] OP_ROL   = 7'd34;
    localparam logic [6:0] OP_ROR   = 7'd35;
    localparam logic [6:0] OP_ASR   = 7'd36;
    localparam logic [6:0] OP_PUSH  = 7'd37;
    localparam logic [6:0] OP_POP   = 7'd38;
    localparam logic [6:0] OP_WSP   = 7'd40;
    localparam logic [6:0] OP_CLC   = 7'd48;
    localparam logic [6:0] OP_SEC   = 7'd49;
    localparam logic [6:0] OP_RET   = 7'd50;
    localparam logic [6:0] OP_SEI   = 7'd52;
    localparam logic [6:0] OP_CLI   = 7'd53;
    localparam logic [6:0] OP_RETID = 7'd54;
    localparam logic [6:0] OP_RETIE = 7'd55;

    // Immediate forms decode on IR_FIVE alone; IR_TWO is immediate data
    localparam logic [4:0] OPI_AND  = 5'b10000;
    localparam logic [4:0] OPI_OR   = 5'b10001;
    localparam logic [4:0] OPI_EXOR = 5'b10010;
    localparam logic [4:0] OPI_TEST = 5'b10011;
    localparam logic [4:0] OPI_ADD  = 5'b10100;
    localparam logic [4:0] OPI_ADDC = 5'b10101;
    localparam logic [4:0] OPI_SUB  = 5'b10110;
    localparam logic [4:0] OPI_SUBC = 5'b10111;
    localparam logic [4:0] OPI_CMP  = 5'b11000;
    localparam logic [4:0] OPI_IN   = 5'b11001;
    localparam logic [4:0] OPI_OUT  = 5'b11010;
    localparam logic [4:0] OPI_MOV  = 5'b11011;
    localparam logic [4:0] OPI_LD   = 5'b11100;
    localparam logic [4:0] OPI_ST   = 5'b11101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDC = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBC = 4'b0011;
    localparam logic [3:0] ALU_CMP  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_EXOR = 4'b0111;
    localparam logic [3:0] ALU_TEST = 4'b1000;
    localparam logic [3:0] ALU_LSL  = 4'b1001;
    localparam logic [3:0] ALU_LSR  = 4'b1010;
    localparam logic [3:0] ALU_ROL  = 4'b1011;
    localparam logic [3:0] ALU_ROR  = 4'b1100;
    localparam logic [3:0] ALU_ASR  = 4'b1101;
    localparam logic [3:0] ALU_MOV  = 4'b1110;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    localparam logic [1:0] PC_SEL_IMM = 2'b00;
    localparam logic [1:0] PC_SEL_STK = 2'b01;
    localparam logic [1:0] PC_SEL_VEC = 2'b10;

    localparam logic [1:0] RF_SEL_ALU = 2'b00;
    localparam logic [1:0] RF_SEL_SCR = 2'b01;
    localparam logic [1:0] RF_SEL_SP  = 2'b10;
    localparam logic [1:0] RF_SEL_IN  = 2'b11;

    localparam logic [1:0] SCR_A_REG  = 2'b00;
    localparam logic [1:0] SCR_A_IMM  = 2'b01;
    localparam logic [1:0] SCR_A_SP   = 2'b10;
    localparam logic [1:0] SCR_A_SPM1 = 2'b11;

    localparam logic SCR_D_REG = 1'b0;
    localparam logic SCR_D_PC  = 1'b1;

    // Index 0..9 follows the AND..MOV ordering shared by reg and imm forms
    function automatic logic [3:0] alu_of(input logic [3:0] idx);
        case (idx)
            4'd0:    alu_of = ALU_AND;
            4'd1:    alu_of = ALU_OR;
            4'd2:    alu_of = ALU_EXOR;
            4'd3:    alu_of = ALU_TEST;
            4'd4:    alu_of = ALU_ADD;
            4'd5:    alu_of = ALU_ADDC;
            4'd6:    alu_of = ALU_SUB;
            4'd7:    alu_of = ALU_SUBC;
            4'd8:    alu_of = ALU_CMP;
            default: alu_of = ALU_MOV;
        endcase
    endfunction

endpackage

// File: rtl/int_pending.sv
// Latched interrupt requests with a fixed-priority encoder;
// bit 0 wins, and a new request beats a coincident acknowledge.
module int_pending
    import mcu_pkg::*;
#(
    parameter int NUM_INT_SRC = 4,
    parameter int INT_ID_W    = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_INT_SRC-1:0] INT_REQ,
    input  logic                   ack,
    input  logic [INT_ID_W-1:0]    ack_id,
    output logic                   any,
    output logic [INT_ID_W-1:0]    id
);

    logic [NUM_INT_SRC-1:0] pending_q;
    logic [NUM_INT_SRC-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_INT_SRC; i++) begin
            if (ack && (ack_id == INT_ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (INT_REQ[i]) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        id = '0;
        for (int i = NUM_INT_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                id = INT_ID_W'(i);
            end
        end
    end

    assign any = |pending_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/mcu_control_fsm.sv
// Multi-cycle RAT MCU control unit: FETCH/EXEC sequencing, branch,
// stack and scratch strobes, and vectored interrupt entry.
module mcu_control_fsm
    import mcu_pkg::*;
#(
    parameter int NUM_INT_SRC = 4,
    parameter int INT_ID_W    = (NUM_INT_SRC > 1) ? $clog2(NUM_INT_SRC) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [4:0]             IR_FIVE,
    input  logic [1:0]             IR_TWO,
    input  logic                   C_FLAG_CONTR,
    input  logic                   Z_FLAG_CONTR,
    input  logic [NUM_INT_SRC-1:0] INT_REQ,
    output logic                   PC_LD,
    output logic                   PC_INC,
    output logic [1:0]             PC_MUX_SEL_MCU,
    output logic                   ALU_OPY_SEL,
    output logic [3:0]             ALU_SEL,
    output logic                   RF_WR,
    output logic [1:0]             RF_WR_SEL,
    output logic                   SP_LD,
    output logic                   SP_INCR,
    output logic                   SP_DECR,
    output logic                   SCR_WE,
    output logic [1:0]             SCR_ADDR_SEL,
    output logic                   SCR_DATA_SEL,
    output logic                   FLG_C_SET,
    output logic                   FLG_C_CLR,
    output logic                   FLG_C_LD,
    output logic                   FLG_Z_LD,
    output logic                   FLG_LD_SEL,
    output logic                   FLG_SHAD_LD,
    output logic                   I_FLAG,
    output logic                   INT_ACK,
    output logic [INT_ID_W-1:0]    INT_ID,
    output logic                   MCU_RST,
    output logic                   IO_STRB
);

    state_t              state_q;
    state_t              state_d;
    logic                ie_q;
    logic                ie_d;
    logic [6:0]          op;
    logic                i_set;
    logic                i_clr;
    logic                op_valid;
    logic                alu_op;
    logic [3:0]          alu_idx;
    logic                int_any;
    logic [INT_ID_W-1:0] int_id;
    logic                ack;

    assign op  = {IR_FIVE, IR_TWO};
    assign ack = (state_q == ST_INTR);

    int_pending #(
        .NUM_INT_SRC(NUM_INT_SRC),
        .INT_ID_W   (INT_ID_W)
    ) u_pend (
        .CLK    (CLK),
        .RESET  (RESET),
        .INT_REQ(INT_REQ),
        .ack    (ack),
        .ack_id (int_id),
        .any    (int_any),
        .id     (int_id)
    );

    always_comb begin
        PC_LD          = 1'b0;
        PC_INC         = 1'b0;
        PC_MUX_SEL_MCU = PC_SEL_IMM;
        ALU_OPY_SEL    = 1'b0;
        ALU_SEL        = ALU_ADD;
        RF_WR          = 1'b0;
        RF_WR_SEL      = RF_SEL_ALU;
        SP_LD          = 1'b0;
        SP_INCR        = 1'b0;
        SP_DECR        = 1'b0;
        SCR_WE         = 1'b0;
        SCR_ADDR_SEL   = SCR_A_REG;
        SCR_DATA_SEL   = SCR_D_REG;
        FLG_C_SET      = 1'b0;
        FLG_C_CLR      = 1'b0;
        FLG_C_LD       = 1'b0;
        FLG_Z_LD       = 1'b0;
        FLG_LD_SEL     = 1'b0;
        FLG_SHAD_LD    = 1'b0;
        INT_ACK        = 1'b0;
        INT_ID         = '0;
        MCU_RST        = 1'b0;
        IO_STRB        = 1'b0;
        i_set          = 1'b0;
        i_clr          = 1'b0;
        op_valid       = 1'b0;
        alu_op         = 1'b0;
        alu_idx        = 4'd0;

        unique case (state_q)
            ST_INIT:  MCU_RST = 1'b1;
            ST_FETCH: PC_INC  = 1'b1;
            ST_EXEC: begin
                if (!op[6] && (op <= OP_MOV)) begin
                    alu_op  = 1'b1;
                    alu_idx = op[3:0];
                end else if (op[6] && (IR_FIVE[3:0] <= 4'd8)) begin
                    alu_op      = 1'b1;
                    alu_idx     = IR_FIVE[3:0];
                    ALU_OPY_SEL = 1'b1;
                end else if (op[6] && (IR_FIVE == OPI_MOV)) begin
                    alu_op      = 1'b1;
                    alu_idx     = 4'd9;
                    ALU_OPY_SEL = 1'b1;
                end

                if (alu_op) begin
                    op_valid = 1'b1;
                    ALU_SEL  = alu_of(alu_idx);
                    // Logical ops clear carry; TEST/CMP only touch flags
                    case (alu_idx)
                        4'd0, 4'd1, 4'd2: begin
                            RF_WR     = 1'b1;
                            FLG_C_CLR = 1'b1;
                            FLG_Z_LD  = 1'b1;
                        end
                        4'd3: begin
                            FLG_C_CLR = 1'b1;
                            FLG_Z_LD  = 1'b1;
                        end
                        4'd4, 4'd5, 4'd6, 4'd7: begin
                            RF_WR    = 1'b1;
                            FLG_C_LD = 1'b1;
                            FLG_Z_LD = 1'b1;
                        end
                        4'd8: begin
                            FLG_C_LD = 1'b1;
                            FLG_Z_LD = 1'b1;
                        end
                        default: RF_WR = 1'b1;
                    endcase
                end else if (op[6]) begin
                    case (IR_FIVE)
                        OPI_IN: begin
                            op_valid  = 1'b1;
                            RF_WR     = 1'b1;
                            RF_WR_SEL = RF_SEL_IN;
                        end
                        OPI_OUT: begin
                            op_valid = 1'b1;
                            IO_STRB  = 1'b1;
                        end
                        OPI_LD: begin
                            op_valid     = 1'b1;
                            RF_WR        = 1'b1;
                            RF_WR_SEL    = RF_SEL_SCR;
                            SCR_ADDR_SEL = SCR_A_IMM;
                        end
                        OPI_ST: begin
                            op_valid     = 1'b1;
                            SCR_WE       = 1'b1;
                            SCR_ADDR_SEL = SCR_A_IMM;
                        end
                        default: ;
                    endcase
                end else begin
                    case (op)
                        OP_LD: begin
                            op_valid     = 1'b1;
                            RF_WR        = 1'b1;
                            RF_WR_SEL    = RF_SEL_SCR;
                            SCR_ADDR_SEL = SCR_A_REG;
                        end
                        OP_ST: begin
                            op_valid     = 1'b1;
                            SCR_WE       = 1'b1;
                            SCR_ADDR_SEL = SCR_A_REG;
                        end
                        OP_BRN: begin
                            op_valid = 1'b1;
                            PC_LD    = 1'b1;
                        end
                        OP_BREQ: begin
                            op_valid = 1'b1;
                            PC_LD    = Z_FLAG_CONTR;
                        end
                        OP_BRNE: begin
                            op_valid = 1'b1;
                            PC_LD    = !Z_FLAG_CONTR;
                        end
                        OP_BRCS: begin
                            op_valid = 1'b1;
                            PC_LD    = C_FLAG_CONTR;
                        end
                        OP_BRCC: begin
                            op_valid = 1'b1;
                            PC_LD    = !C_FLAG_CONTR;
                        end
                        OP_CALL: begin
                            op_valid     = 1'b1;
                            PC_LD        = 1'b1;
                            SCR_WE       = 1'b1;
                            SCR_DATA_SEL = SCR_D_PC;
                            SCR_ADDR_SEL = SCR_A_SPM1;
                            SP_DECR      = 1'b1;
                        end
                        OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR: begin
                            op_valid = 1'b1;
                            RF_WR    = 1'b1;
                            FLG_C_LD = 1'b1;
                            FLG_Z_LD = 1'b1;
                            ALU_SEL  = ALU_LSL + {1'b0, op[2:0]};
                        end
                        OP_PUSH: begin
                            op_valid     = 1'b1;
                            SCR_WE       = 1'b1;
                            SCR_ADDR_SEL = SCR_A_SPM1;
                            SP_DECR      = 1'b1;
                        end
                        OP_POP: begin
                            op_valid     = 1'b1;
                            RF_WR        = 1'b1;
                            RF_WR_SEL    = RF_SEL_SCR;
                            SCR_ADDR_SEL = SCR_A_SP;
                            SP_INCR      = 1'b1;
                        end
                        OP_WSP: begin
                            op_valid = 1'b1;
                            SP_LD    = 1'b1;
                        end
                        OP_CLC: begin
                            op_valid  = 1'b1;
                            FLG_C_CLR = 1'b1;
                        end
                        OP_SEC: begin
                            op_valid  = 1'b1;
                            FLG_C_SET = 1'b1;
                        end
                        OP_RET: begin
                            op_valid       = 1'b1;
                            PC_LD          = 1'b1;
                            PC_MUX_SEL_MCU = PC_SEL_STK;
                            SCR_ADDR_SEL   = SCR_A_SP;
                            SP_INCR        = 1'b1;
                        end
                        OP_SEI: begin
                            op_valid = 1'b1;
                            i_set    = 1'b1;
                        end
                        OP_CLI: begin
                            op_valid = 1'b1;
                            i_clr    = 1'b1;
                        end
                        OP_RETID, OP_RETIE: begin
                            op_valid       = 1'b1;
                            PC_LD          = 1'b1;
                            PC_MUX_SEL_MCU = PC_SEL_STK;
                            SCR_ADDR_SEL   = SCR_A_SP;
                            SP_INCR        = 1'b1;
                            FLG_LD_SEL     = 1'b1;
                            FLG_C_LD       = 1'b1;
                            FLG_Z_LD       = 1'b1;
                            i_set          = (op == OP_RETIE);
                            i_clr          = (op == OP_RETID);
                        end
                        default: ;
                    endcase
                end
            end
            ST_INTR: begin
                PC_LD          = 1'b1;
                PC_MUX_SEL_MCU = PC_SEL_VEC;
                SCR_WE         = 1'b1;
                SCR_DATA_SEL   = SCR_D_PC;
                SCR_ADDR_SEL   = SCR_A_SPM1;
                SP_DECR        = 1'b1;
                FLG_SHAD_LD    = 1'b1;
                i_clr          = 1'b1;
                INT_ACK        = 1'b1;
                INT_ID         = int_id;
            end
            default: ;
        endcase
    end

    assign I_FLAG = ie_q;

    // Entry uses the registered enable; a CLI in this EXEC still blocks it
    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        if (i_set) ie_d = 1'b1;
        if (i_clr) ie_d = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (ie_q && !i_clr && op_valid && int_any) begin
                    state_d = ST_INTR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_INTR:  state_d = ST_FETCH;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_INIT;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
        end
    end

endmodule
